// File: rtl/mips_fetch_unit.sv
// Instruction-fetch and next-PC unit: owns the PC, fetches over a ready handshake,
// holds each instruction for the controller and resolves branch/jump targets on ack.
module mips_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        instr_valid,
  input  logic        instr_ack,
  input  logic        branch,
  input  logic        jump,
  input  logic        zero,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr_count
);

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state;
  logic        taken;
  logic [31:0] branch_off;
  logic [31:0] next_pc;

  assign opcode    = instr[31:26];
  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;

  // opcode[0] separates bne (taken on ~zero) from beq (taken on zero); jump outranks branch
  always_comb begin
    taken      = branch & (opcode[0] ? ~zero : zero);
    branch_off = {{14{instr[15]}}, instr[15:0], 2'b00};
    next_pc    = pc_plus4;
    if (jump) begin
      next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
    end else if (taken) begin
      next_pc = pc_plus4 + branch_off;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC_ALIGNED;
      imem_req    <= 1'b0;
      instr       <= 32'h0;
      instr_valid <= 1'b0;
      instr_count <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (imem_ready) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (instr_ack) begin
            pc          <= {next_pc[31:2], 2'b00};
            instr_valid <= 1'b0;
            instr_count <= instr_count + 32'd1;
            imem_req    <= 1'b1;
            state       <= FETCH;
          end
        end
        default: begin
          state       <= IDLE;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed bench for mips_fetch_unit: sequential fetch, stalls, beq/bne, jump, wrap, async reset.
module tb_mips_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        instr_ack;
  logic        branch;
  logic        jump;
  logic        zero;

  logic        imem_req, d2_imem_req;
  logic [31:0] imem_addr, d2_imem_addr;
  logic [31:0] instr, d2_instr;
  logic [5:0]  opcode, d2_opcode;
  logic        instr_valid, d2_instr_valid;
  logic [31:0] pc, d2_pc;
  logic [31:0] pc_plus4, d2_pc_plus4;
  logic [31:0] instr_count, d2_instr_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr(instr), .opcode(opcode),
    .instr_valid(instr_valid), .instr_ack(instr_ack), .branch(branch), .jump(jump),
    .zero(zero), .pc(pc), .pc_plus4(pc_plus4), .instr_count(instr_count)
  );

  // Second instance in the 0x4xxx_xxxx region to exercise jump upper-nibble reuse
  mips_fetch_unit #(.RESET_PC(32'h4000_0000)) dut_hi (
    .clk(clk), .rst_n(rst_n), .imem_req(d2_imem_req), .imem_addr(d2_imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr(d2_instr), .opcode(d2_opcode),
    .instr_valid(d2_instr_valid), .instr_ack(instr_ack), .branch(branch), .jump(jump),
    .zero(zero), .pc(d2_pc), .pc_plus4(d2_pc_plus4), .instr_count(d2_instr_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Called at a negedge while in FETCH; returns at the negedge after capture.
  task automatic fetch_instr(input logic [31:0] addr, input logic [31:0] word,
                             input int stalls, input logic [31:0] prev);
    for (int i = 0; i < stalls; i++) begin
      imem_ready = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
      check("stall_req", 32'(imem_req), 32'd1);
      check("stall_addr", imem_addr, addr);
      check("stall_instr", instr, prev);
      @(negedge clk);
    end
    imem_ready = 1'b1;
    imem_rdata = word;
    check("fetch_req", 32'(imem_req), 32'd1);
    check("fetch_addr", imem_addr, addr);
    check("fetch_valid_low", 32'(instr_valid), 32'd0);
    @(negedge clk);
    imem_ready = 1'b0;
    check("hold_valid", 32'(instr_valid), 32'd1);
    check("hold_instr", instr, word);
    check("hold_req_low", 32'(imem_req), 32'd0);
  endtask

  // Called at a negedge in HOLD; returns at the negedge after the ack edge.
  task automatic ack_instr(input logic br, input logic jp, input logic z, input int holds,
                           input logic [31:0] word, input logic [31:0] exp_pc);
    for (int i = 0; i < holds; i++) begin
      instr_ack  = 1'b0;
      imem_ready = 1'b1;
      imem_rdata = ~word;
      @(negedge clk);
      check("hold_stable_instr", instr, word);
      check("hold_stable_valid", 32'(instr_valid), 32'd1);
    end
    imem_ready = 1'b0;
    instr_ack  = 1'b1;
    branch     = br;
    jump       = jp;
    zero       = z;
    @(negedge clk);
    instr_ack = 1'b0;
    branch    = 1'b0;
    jump      = 1'b0;
    zero      = 1'b0;
    check("ack_valid_low", 32'(instr_valid), 32'd0);
    check("ack_req", 32'(imem_req), 32'd1);
    check("next_pc", pc, exp_pc);
    check("next_addr", imem_addr, exp_pc);
  endtask

  initial begin
    rst_n      = 1'b0;
    imem_ready = 1'b0;
    imem_rdata = 32'h0;
    instr_ack  = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    zero       = 1'b0;

    @(negedge clk);
    check("rst_pc", pc, 32'h0);
    check("rst_pc_plus4", pc_plus4, 32'h4);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_opcode", 32'(opcode), 32'h0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_count", instr_count, 32'h0);
    check("rst_hi_pc", d2_pc, 32'h4000_0000);
    rst_n = 1'b1;
    @(negedge clk);
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", imem_addr, 32'h0);

    // sequential fetch with a 3-cycle stall on address 4
    fetch_instr(32'h0, 32'h2000_0001, 0, 32'h0);
    ack_instr(1'b0, 1'b0, 1'b0, 0, 32'h2000_0001, 32'h4);
    fetch_instr(32'h4, 32'h2000_0002, 3, 32'h2000_0001);
    ack_instr(1'b0, 1'b0, 1'b0, 2, 32'h2000_0002, 32'h8);
    fetch_instr(32'h8, 32'h2000_0003, 0, 32'h2000_0002);
    ack_instr(1'b0, 1'b0, 1'b0, 0, 32'h2000_0003, 32'hC);
    fetch_instr(32'hC, 32'h2000_0004, 0, 32'h2000_0003);
    ack_instr(1'b0, 1'b0, 1'b0, 0, 32'h2000_0004, 32'h10);
    check("count_4", instr_count, 32'd4);

    // beq taken / back / not taken
    fetch_instr(32'h10, 32'h1000_0003, 0, 32'h2000_0004);
    check("beq_opcode", 32'(opcode), 32'h04);
    ack_instr(1'b1, 1'b0, 1'b1, 0, 32'h1000_0003, 32'h20);
    fetch_instr(32'h20, 32'h1000_FFFB, 0, 32'h1000_0003);
    ack_instr(1'b1, 1'b0, 1'b1, 0, 32'h1000_FFFB, 32'h10);
    fetch_instr(32'h10, 32'h1000_0003, 0, 32'h1000_FFFB);
    ack_instr(1'b1, 1'b0, 1'b0, 0, 32'h1000_0003, 32'h14);
    fetch_instr(32'h14, 32'h1000_FFFE, 0, 32'h1000_0003);
    ack_instr(1'b1, 1'b0, 1'b1, 0, 32'h1000_FFFE, 32'h10);

    // bne taken on zero=0, not taken on zero=1
    fetch_instr(32'h10, 32'h1400_FFFE, 0, 32'h1000_FFFE);
    check("bne_opcode", 32'(opcode), 32'h05);
    ack_instr(1'b1, 1'b0, 1'b0, 0, 32'h1400_FFFE, 32'hC);
    fetch_instr(32'hC, 32'h2000_0005, 0, 32'h1400_FFFE);
    ack_instr(1'b0, 1'b0, 1'b0, 0, 32'h2000_0005, 32'h10);
    fetch_instr(32'h10, 32'h1400_FFFE, 0, 32'h2000_0005);
    ack_instr(1'b1, 1'b0, 1'b1, 0, 32'h1400_FFFE, 32'h14);

    // jump to 0, negative branch wraps to 0xFFFF_FFFC, then increment wraps to 0
    fetch_instr(32'h14, 32'h0800_0000, 0, 32'h1400_FFFE);
    ack_instr(1'b0, 1'b1, 1'b0, 0, 32'h0800_0000, 32'h0);
    fetch_instr(32'h0, 32'h1000_FFFE, 0, 32'h0800_0000);
    ack_instr(1'b1, 1'b0, 1'b1, 0, 32'h1000_FFFE, 32'hFFFF_FFFC);
    check("wrap_pc_plus4", pc_plus4, 32'h0);
    fetch_instr(32'hFFFF_FFFC, 32'h2000_0006, 0, 32'h1000_FFFE);
    ack_instr(1'b0, 1'b0, 1'b0, 0, 32'h2000_0006, 32'h0);
    check("count_14", instr_count, 32'd14);

    // async reset mid-fetch, with imem_ready pulsed during reset and at release
    #2 rst_n = 1'b0;
    #1;
    check("arst_req", 32'(imem_req), 32'd0);
    check("arst_pc", pc, 32'h0);
    check("arst_instr", instr, 32'h0);
    check("arst_count", instr_count, 32'h0);
    check("arst_valid", 32'(instr_valid), 32'd0);
    imem_ready = 1'b1;
    imem_rdata = 32'h2000_0007;
    @(posedge clk);
    #1;
    check("arst_ready_ignored", instr, 32'h0);
    check("arst_valid_hold", 32'(instr_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    check("restart_req", 32'(imem_req), 32'd1);
    check("restart_addr", imem_addr, 32'h0);
    check("idle_ready_ignored", instr, 32'h0);
    check("restart_valid", 32'(instr_valid), 32'd0);

    // jump beats branch; upper nibble comes from pc_plus4
    fetch_instr(32'h0, 32'h0800_0010, 0, 32'h0);
    ack_instr(1'b1, 1'b1, 1'b1, 0, 32'h0800_0010, 32'h40);
    check("jump_hi_pc", d2_pc, 32'h4000_0040);
    check("count_after_rst", instr_count, 32'd1);
    check("count_hi", d2_instr_count, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_fetch_unit.md
# mips_fetch_unit

Instruction-fetch and next-PC block for the MIPS core: owns the program counter, reads instructions from instruction memory over a ready-based handshake, and presents each instruction and its 6-bit opcode to the main controller. It consumes the controller's branch/jump decisions and the ALU zero flag to select the next PC: plain increment, beq/bne branch, or J-format jump. It sits between instruction memory and the controller/datapath and is the source of every opcode the controller decodes.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0
- clk  in  1  core clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request; held until accepted
- imem_addr  out  32  fetch address (= pc), stable while imem_req=1
- imem_ready  in  1  memory accepts the request and drives imem_rdata this cycle
- imem_rdata  in  32  instruction word, valid when imem_ready=1
- instr  out  32  held instruction
- opcode  out  6  instr[31:26], to controller
- instr_valid  out  1  instr/opcode valid, awaiting instr_ack
- instr_ack  in  1  datapath has finished the instruction; branch/jump/zero valid this cycle
- branch  in  1  controller Branch (beq or bne)
- jump  in  1  controller jump request
- zero  in  1  ALU zero flag
- pc  out  32  address of the held instruction
- pc_plus4  out  32  pc + 4, mod 2^32
- instr_count  out  32  count of acknowledged instructions, wraps

## Operation
- States: IDLE, FETCH, HOLD.
- IDLE: reset state only; unconditionally goes to FETCH at the first clock edge after reset release.
- FETCH: imem_req=1, imem_addr=pc. On an edge with imem_ready=1:
  - capture imem_rdata into instr
  - set instr_valid=1, clear imem_req
  - go to HOLD
  Otherwise stay in FETCH; the request holds with the same address.
- HOLD: instr_valid=1, imem_req=0. On an edge with instr_ack=1:
  - load pc with next_pc
  - clear instr_valid
  - increment instr_count
  - go to FETCH
- imem_ready is ignored outside FETCH. instr_ack is ignored outside HOLD.
- Branch decision: taken = branch & (opcode[0] ? ~zero : zero). Opcode 000100 is beq; opcode 000101 is bne.
- next_pc, in priority order:
  - jump=1: {pc_plus4[31:28], instr[25:0], 2'b00}
  - else taken: pc_plus4 + ({{14{instr[15]}}, instr[15:0], 2'b00})
  - else pc_plus4
- Arithmetic is 32-bit modulo 2^32: 32'hFFFF_FFFC + 4 = 0, and negative offsets wrap.
- jump and branch both high: jump wins.
- pc[1:0] is always 0; imem_addr[1:0] = 0.

## Timing
- Reset values: state=IDLE, pc=RESET_PC, pc_plus4=RESET_PC+4, imem_req=0, instr=0, opcode=0, instr_valid=0, instr_count=0.
- All outputs are registered, except opcode=instr[31:26], imem_addr=pc and pc_plus4=pc+4.
- Zero-wait memory: FETCH is 1 cycle and HOLD is at least 1 cycle, so peak throughput is 1 instruction per 2 cycles.
- Edge-by-edge after reset release:
  - edge 1: enter FETCH, imem_req rises.
  - edge 2: if imem_ready=1, instr_valid rises.
  - edge 3: if instr_ack=1, pc updates and the next imem_req is asserted.
- Each wait cycle of imem_ready=0 adds one cycle in FETCH. Each cycle of instr_ack=0 adds one cycle in HOLD, with instr, pc and opcode held stable.
- Reset asserted mid-operation: all state returns to reset values immediately, without waiting for clk. An outstanding request is abandoned. An imem_ready arriving while rst_n=0 or in IDLE is ignored.
- instr_count wraps 32'hFFFF_FFFF -> 0 on ack.

## Test plan
- Reset/sequential fetch: RESET_PC=0, zero-wait memory, instr_ack every HOLD cycle.
  - imem_addr sequence 0,4,8,C.
  - instr_valid high every other cycle.
  - instr_count=4 after 4 acks.
- Memory stalls: imem_ready low for 3 cycles on the fetch from 4.
  - imem_req and imem_addr=4 held stable for 4 cycles.
  - instr captured only on the ready cycle.
- beq/bne: pc=0x10, instr=0x1000_0003 (beq), branch=1, zero=1 -> next pc=0x20.
  - Same instruction with zero=0 -> 0x14.
  - instr=0x1400_FFFE (bne), zero=0 -> 0x0C.
  - Same bne with zero=1 -> 0x14.
- Jump priority and wrap:
  - pc=0x4000_0000, instr=0x0800_0010, jump=1 and branch=1 -> next pc=0x4000_0040.
  - pc=0xFFFF_FFFC with no branch or jump -> next pc=0.
- Async reset mid-fetch: drop rst_n while in FETCH with imem_req=1.
  - Outputs go to reset values before the next clk edge.
  - imem_ready pulsed during reset has no effect.
  - Fetching restarts at RESET_PC.
